// File: rtl/topk_uart_pkg.sv
// Shared frame-state type and framing constants for the top-k result UART link.
// The framing matches the host-to-FPGA query loader, so both directions share one host parser.
package topk_uart_pkg;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SYNC,
    FR_DATA,
    FR_TRAILER
  } frame_state_e;

  localparam logic [31:0] SYNC_WORD            = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD       = 4;
  localparam int          DEFAULT_CLKS_PER_BIT = 180;

  // Bytes leave the link LSB byte first.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/topk_uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready byte input and CTS gating of start bits.
// A byte already on the line always completes; the next byte may start on the stop bit's last cycle.
module uart_byte_tx
  import topk_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic       byte_ready_out,
  input  logic       uart_cts_n_in,
  output logic       done_out,
  output logic       txd_out
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  tx_state_e     state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;

  logic bit_end;
  logic take;

  assign bit_end        = (baud_q == BAUD_LAST);
  assign done_out       = (state_q == TX_STOP) && bit_end;
  // Accepting during the stop bit's final cycle keeps consecutive bytes gap-free.
  assign byte_ready_out = !uart_cts_n_in && ((state_q == TX_IDLE) || done_out);
  assign take           = byte_valid_in && byte_ready_out;
  assign txd_out        = txd_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else if (take) begin
      state_q <= TX_START;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= byte_in;
      txd_q   <= 1'b0;
    end else begin
      case (state_q)
        TX_START: begin
          if (bit_end) begin
            state_q <= TX_DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= TX_IDLE;
          baud_q  <= '0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/topk_uart_tx.sv
// Frames top-k result sets as SYNC_WORD, result words, cycle-count trailer and sends them over UART.
// One word register decouples the result FIFO from the byte serializer.
module topk_uart_tx #(
  parameter int          CLKS_PER_BIT = topk_uart_pkg::DEFAULT_CLKS_PER_BIT,
  parameter logic [31:0] SYNC_WORD    = topk_uart_pkg::SYNC_WORD
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] result_in,
  input  logic        result_valid_in,
  input  logic        result_last_in,
  output logic        result_ready_out,
  input  logic [31:0] cycles_in,
  input  logic        uart_cts_n_in,
  output logic        uart_txd_out,
  output logic        busy_out,
  output logic [15:0] frames_sent_out
);

  import topk_uart_pkg::*;

  frame_state_e state_q;
  logic [31:0]  word_q;
  logic [31:0]  cycles_q;
  logic         full_q;
  logic         last_q;
  logic         trl_sent_q;
  logic         alive_q;
  logic [1:0]   byte_idx_q;
  logic [15:0]  frames_q;

  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_take;
  logic       accept;
  logic       last_byte;

  always_comb begin
    tx_byte  = '0;
    tx_valid = 1'b0;
    case (state_q)
      FR_SYNC: begin
        tx_byte  = word_byte(SYNC_WORD, byte_idx_q);
        tx_valid = 1'b1;
      end
      FR_DATA: begin
        tx_byte  = word_byte(word_q, byte_idx_q);
        tx_valid = full_q;
      end
      FR_TRAILER: begin
        tx_byte  = word_byte(cycles_q, byte_idx_q);
        tx_valid = !trl_sent_q;
      end
      default: ;
    endcase
  end

  // alive_q holds ready low until the first edge after reset release.
  assign result_ready_out = alive_q && !full_q && ((state_q == FR_IDLE) || (state_q == FR_DATA));
  assign accept           = result_valid_in && result_ready_out;
  assign tx_take          = tx_valid && tx_ready;
  assign last_byte        = (byte_idx_q == 2'(BYTES_PER_WORD - 1));
  assign busy_out         = (state_q != FR_IDLE);
  assign frames_sent_out  = frames_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= FR_IDLE;
      word_q     <= '0;
      cycles_q   <= '0;
      full_q     <= 1'b0;
      last_q     <= 1'b0;
      trl_sent_q <= 1'b0;
      alive_q    <= 1'b0;
      byte_idx_q <= '0;
      frames_q   <= '0;
    end else begin
      alive_q <= 1'b1;
      if (accept) begin
        word_q <= result_in;
        last_q <= result_last_in;
        full_q <= 1'b1;
        if (result_last_in) begin
          cycles_q <= cycles_in;
        end
      end
      if (tx_take) begin
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      case (state_q)
        FR_IDLE: begin
          if (accept) state_q <= FR_SYNC;
        end
        FR_SYNC: begin
          if (tx_take && last_byte) state_q <= FR_DATA;
        end
        FR_DATA: begin
          // Emptying on the 4th handoff lets the next word land while that byte is on the line.
          if (tx_take && last_byte) begin
            full_q <= 1'b0;
            if (last_q) state_q <= FR_TRAILER;
          end
        end
        FR_TRAILER: begin
          if (tx_take && last_byte) trl_sent_q <= 1'b1;
          if (trl_sent_q && tx_done) begin
            state_q    <= FR_IDLE;
            trl_sent_q <= 1'b0;
            frames_q   <= frames_q + 16'd1;
          end
        end
        default: state_q <= FR_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .byte_in       (tx_byte),
    .byte_valid_in (tx_valid),
    .byte_ready_out(tx_ready),
    .uart_cts_n_in (uart_cts_n_in),
    .done_out      (tx_done),
    .txd_out       (uart_txd_out)
  );

endmodule

// File: tb/tb_topk_uart_tx.sv
// Self-checking bench for topk_uart_tx: UART byte decoder, frame model, vector table and corner sequences.
module tb_topk_uart_tx;

  localparam int CPB = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] result_in;
  logic        result_valid_in;
  logic        result_last_in;
  logic        result_ready_out;
  logic [31:0] cycles_in;
  logic        uart_cts_n_in;
  logic        uart_txd_out;
  logic        busy_out;
  logic [15:0] frames_sent_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  int ready_falls = 0;
  bit rnd_cts_on = 1'b0;
  logic [15:0] exp_frames = '0;

  logic [7:0]  rx_q[$];
  int          rx_t[$];
  logic [7:0]  exp_q[$];
  logic [31:0] tx_words[$];

  typedef struct {
    string       name;
    int          n;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] cyc_v;
    int          gap_after;
    int          gap_len;
    int          exp_len;
    int          exp_falls;
  } vec_t;

  vec_t vecs[4];

  topk_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_WORD   (32'hFFFF_FFFF)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .result_in       (result_in),
    .result_valid_in (result_valid_in),
    .result_last_in  (result_last_in),
    .result_ready_out(result_ready_out),
    .cycles_in       (cycles_in),
    .uart_cts_n_in   (uart_cts_n_in),
    .uart_txd_out    (uart_txd_out),
    .busy_out        (busy_out),
    .frames_sent_out (frames_sent_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // UART decoder: samples each bit 1.5 cycles after its start.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in === 1'b1 && uart_txd_out === 1'b0) begin
        int e0, t0;
        logic [7:0] b;
        bit ok;
        e0 = epoch;
        t0 = cyc;
        ok = 1'b1;
        @(negedge clk_in);
        if (uart_txd_out !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_in);
          b[i] = uart_txd_out;
        end
        repeat (CPB) @(negedge clk_in);
        if (epoch == e0) begin
          checks++;
          if (!ok || uart_txd_out !== 1'b1) begin
            errors++;
            $display("FAIL uart_framing: start_ok=%0b stop=%b, required start 0 and stop 1", ok, uart_txd_out);
          end
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_in);
      if (prev === 1'b1 && result_ready_out === 1'b0) ready_falls++;
      prev = result_ready_out;
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (rnd_cts_on && $urandom_range(0, 39) == 0) uart_cts_n_in = ~uart_cts_n_in;
    end
  end

  // Reference model: sync word, result words, trailer; each word LSB byte first.
  task automatic model_frame(input logic [31:0] cyc_v);
    logic [31:0] ws[$];
    ws.push_back(32'hFFFF_FFFF);
    foreach (tx_words[i]) ws.push_back(tx_words[i]);
    ws.push_back(cyc_v);
    foreach (ws[i]) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((ws[i] >> (8 * k)) & 32'hFF));
    end
  endtask

  task automatic send_frame(input logic [31:0] cyc_v, input int gap_after, input int gap_len);
    for (int i = 0; i < tx_words.size(); i++) begin
      int wait_n;
      bit idle_bad;
      wait_n = 0;
      idle_bad = 1'b0;
      result_in       = tx_words[i];
      result_last_in  = (i == tx_words.size() - 1);
      cycles_in       = result_last_in ? cyc_v : $urandom;
      result_valid_in = 1'b1;
      while (result_ready_out !== 1'b1 && wait_n < 5000) begin
        @(negedge clk_in);
        wait_n++;
      end
      if (wait_n >= 5000) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: word %0d not accepted in %0d cycles, required acceptance", i, wait_n);
      end
      @(negedge clk_in);
      result_valid_in = 1'b0;
      result_in       = $urandom;
      result_last_in  = 1'($urandom_range(0, 1));
      cycles_in       = $urandom;
      if (i == gap_after) begin
        for (int j = 0; j < gap_len; j++) begin
          @(negedge clk_in);
          if (j >= gap_len - 50 && (uart_txd_out !== 1'b1 || busy_out !== 1'b1)) idle_bad = 1'b1;
        end
        if (gap_len >= 250) begin
          checks++;
          if (idle_bad) begin
            errors++;
            $display("FAIL starve_idle: txd/busy not held at 1/1 during producer gap, required 1/1");
          end
        end
      end
    end
  endtask

  task automatic check_frame(input string name, input int exp_len, input int exp_falls);
    int w, end_c, nb, bad, gaps_bad;
    w = 0;
    bad = 0;
    gaps_bad = 0;
    while (busy_out === 1'b1 && w < 20000) begin
      @(negedge clk_in);
      w++;
    end
    end_c = cyc;
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_end: busy=%b after %0d cycles, required 0", name, busy_out, w);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s byte_count: got %0d, required %0d", name, rx_q.size(), exp_q.size());
    end
    nb = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        bad++;
        $display("FAIL %s byte[%0d]: got %02h, required %02h", name, i, rx_q[i], exp_q[i]);
      end
    end
    if (exp_len > 0 && rx_t.size() > 0) begin
      checks++;
      if (end_c - rx_t[0] != exp_len) begin
        errors++;
        $display("FAIL %s frame_len: got %0d cycles, required %0d", name, end_c - rx_t[0], exp_len);
      end
      for (int i = 1; i < rx_t.size(); i++) if (rx_t[i] - rx_t[i-1] != 10 * CPB) gaps_bad++;
      checks++;
      if (gaps_bad != 0) begin
        errors++;
        $display("FAIL %s byte_gaps: %0d spacings differ, required all %0d", name, gaps_bad, 10 * CPB);
      end
    end
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (frames_sent_out !== exp_frames) begin
      errors++;
      $display("FAIL %s frames_sent: got %0d, required %0d", name, frames_sent_out, exp_frames);
    end
    checks++;
    if (result_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %b, required 1", name, result_ready_out);
    end
    if (exp_falls > 0) begin
      checks++;
      if (ready_falls != exp_falls) begin
        errors++;
        $display("FAIL %s ready_toggles: got %0d, required %0d", name, ready_falls, exp_falls);
      end
    end
    $display("frame %-10s words=%0d bytes=%0d byte_errors=%0d frames_sent=%0d", name, tx_words.size(), rx_q.size(), bad, frames_sent_out);
  endtask

  task automatic prep(input logic [31:0] cyc_v);
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
    ready_falls = 0;
    model_frame(cyc_v);
  endtask

  task automatic run_frame(input string name, input logic [31:0] cyc_v, input int gap_after,
                           input int gap_len, input int exp_len, input int exp_falls);
    prep(cyc_v);
    send_frame(cyc_v, gap_after, gap_len);
    check_frame(name, exp_len, exp_falls);
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  initial begin
    vecs[0] = '{"single",  1, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 32'h0000_0123, -1,   0, 480, 1};
    vecs[1] = '{"four_b2b", 4, 32'h5, 32'h7, 32'h1, 32'h1,         32'hDEAD_BEEF, -1,   0, 960, 4};
    vecs[2] = '{"starved", 4, 32'hA1B2_C3D4, 32'h0102_0304, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_BEEF, 1, 300, -1, 4};
    vecs[3] = '{"two_word", 2, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 32'h0, 32'h1234_5678, -1,  0, 640, 2};

    rst_in          = 1'b1;
    result_in       = '0;
    result_valid_in = 1'b0;
    result_last_in  = 1'b0;
    cycles_in       = '0;
    uart_cts_n_in   = 1'b0;
    #1 rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_bit("reset_txd", uart_txd_out, 1'b1);
    check_bit("reset_ready", result_ready_out, 1'b0);
    check_bit("reset_busy", busy_out, 1'b0);
    checks++;
    if (frames_sent_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_frames: got %0d, required 0", frames_sent_out);
    end
    rst_in = 1'b1;
    check_bit("ready_before_edge", result_ready_out, 1'b0);
    @(negedge clk_in);
    check_bit("ready_after_edge", result_ready_out, 1'b1);

    foreach (vecs[v]) begin
      tx_words.delete();
      if (vecs[v].n > 0) tx_words.push_back(vecs[v].w0);
      if (vecs[v].n > 1) tx_words.push_back(vecs[v].w1);
      if (vecs[v].n > 2) tx_words.push_back(vecs[v].w2);
      if (vecs[v].n > 3) tx_words.push_back(vecs[v].w3);
      run_frame(vecs[v].name, vecs[v].cyc_v, vecs[v].gap_after, vecs[v].gap_len,
                vecs[v].exp_len, vecs[v].exp_falls);
    end

    // CTS raised mid-byte: the byte completes, no new start bit until CTS returns.
    tx_words.delete();
    tx_words.push_back(32'h1122_3344);
    tx_words.push_back(32'h5566_7788);
    prep(32'hCAFE_0001);
    fork
      send_frame(32'hCAFE_0001, -1, 0);
      begin
        int wc;
        wc = 0;
        while (rx_q.size() < 5 && wc < 5000) begin
          @(negedge clk_in);
          wc++;
        end
        repeat (15) @(negedge clk_in);
        uart_cts_n_in = 1'b1;
        repeat (120) @(negedge clk_in);
        checks++;
        if (rx_q.size() != 6 || uart_txd_out !== 1'b1) begin
          errors++;
          $display("FAIL cts_hold: bytes=%0d txd=%b, required 6 and 1", rx_q.size(), uart_txd_out);
        end
        uart_cts_n_in = 1'b0;
      end
    join
    check_frame("cts_stall", -1, 2);

    // Reset during a data bit of the first result word (all-zero data keeps txd low).
    tx_words.delete();
    tx_words.push_back(32'h0000_0000);
    prep(32'h0000_0077);
    send_frame(32'h0000_0077, -1, 0);
    begin
      int wr;
      wr = 0;
      while (rx_q.size() < 4 && wr < 5000) begin
        @(negedge clk_in);
        wr++;
      end
    end
    repeat (10) @(negedge clk_in);
    check_bit("pre_reset_txd_low", uart_txd_out, 1'b0);
    #1;
    epoch++;
    rst_in = 1'b0;
    #1;
    check_bit("rst_txd_async", uart_txd_out, 1'b1);
    check_bit("rst_ready", result_ready_out, 1'b0);
    check_bit("rst_busy", busy_out, 1'b0);
    checks++;
    if (frames_sent_out !== 16'd0) begin
      errors++;
      $display("FAIL rst_frames: got %0d, required 0", frames_sent_out);
    end
    exp_frames = 16'd0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (50) @(negedge clk_in);
    check_bit("post_reset_txd_idle", uart_txd_out, 1'b1);
    tx_words.delete();
    tx_words.push_back(32'hA5A5_0F0F);
    run_frame("after_rst", 32'h0000_0042, -1, 0, 480, 1);

    // Randomized frames with random producer gaps and CTS toggling.
    for (int r = 0; r < 6; r++) begin
      int n;
      logic [31:0] cv;
      n = $urandom_range(1, 4);
      tx_words.delete();
      for (int i = 0; i < n; i++) tx_words.push_back(($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom);
      cv = $urandom;
      rnd_cts_on = 1'b1;
      run_frame($sformatf("rand%0d", r), cv, $urandom_range(0, 3), $urandom_range(0, 60), -1, n);
      rnd_cts_on = 1'b0;
      uart_cts_n_in = 1'b0;
      @(negedge clk_in);
    end

    // Counter wrap: preload 0xFFFF, one more frame must give 0.
    force dut.frames_q = 16'hFFFF;
    @(negedge clk_in);
    release dut.frames_q;
    @(negedge clk_in);
    checks++;
    if (frames_sent_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %0d, required 65535", frames_sent_out);
    end
    exp_frames = 16'hFFFF;
    tx_words.delete();
    tx_words.push_back(32'h0BAD_F00D);
    run_frame("wrap", 32'h0000_0009, -1, 0, 480, 1);
    checks++;
    if (frames_sent_out !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: got %0d, required 0", frames_sent_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
